// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer
// Sequences an external bank of WIDTH T flip-flops as a synchronous up/down
// counter. A start request clears the bank to 0 (up) or all-ones (down), then
// the bank counts toward a captured limit. The block pulses done for one cycle
// when the count completes. An abort returns the block to idle with the bank
// holding its current value. The t outputs are combinational from the state,
// the captured direction and the fed-back q, so the bank steps on the same
// edge that advances the state machine.

module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             dir_r;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] t_s;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;

    // Bit i of a binary counter toggles when every lower bit is 1. Counting
    // down is the same rule applied to the complemented value.
    function automatic logic [WIDTH-1:0] carry_mask(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] mask;
        logic             run;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = run;
            run     = run & value[i];
        end
        return mask;
    endfunction

    assign accept_s = (state_r == ST_IDLE) && start && !abort;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture direction and terminal count when a sequence is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_r   <= 1'b0;
            limit_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            dir_r   <= dir;
            limit_r <= limit;
        end else begin
            dir_r   <= dir_r;
            limit_r <= limit_r;
        end
    end

    // Next-state and toggle-mask decode.
    always_comb begin
        next_state_s = state_r;
        t_s          = {WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else begin
                    // Toggling the ones (up) or the zeros (down) lands the
                    // bank on all-zeros or all-ones at the next edge.
                    t_s          = dir_r ? ~q : q;
                    next_state_s = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (q == limit_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    t_s          = dir_r ? carry_mask(~q) : carry_mask(q);
                    next_state_s = ST_COUNT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they mirror state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_CLEAR) || (next_state_s == ST_COUNT);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign t    = t_s;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: doc/tff_count_sequencer.md
Name: tff_count_sequencer

Overview:
- Controller that sequences an external bank of WIDTH T flip-flops (per-bit t, clk, rst; Q fed back) as a synchronous up/down counter.
- On a start request it clears the bank to a mode-dependent start value, then counts to a captured limit.
- It pulses done on completion and supports abort.
- Sits beside the T-FF bank. Only this block drives the bank's t inputs.

Parameters:
- WIDTH, 4, number of T flip-flops in the controlled bank (2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a count sequence; sampled only in IDLE.
- abort  input  1  terminate an active sequence.
- dir  input  1  0 = count up, 1 = count down; captured at start.
- limit  input  WIDTH  terminal count; captured at start.
- q  input  WIDTH  Q outputs fed back from the T-FF bank.
- t  output  WIDTH  toggle inputs to the T-FF bank; combinational from state, captured dir and q.
- busy  output  1  high while in CLEAR or COUNT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE; dir_r=0, limit_r=0, busy=0, done=0; t=0 while in IDLE.
- States: IDLE, CLEAR, COUNT, DONE. State is registered; busy and done decode from the state register.
- IDLE:
  - t=0.
  - start=1 and abort=0 at an edge: capture dir_r<=dir and limit_r<=limit, next=CLEAR.
  - start and abort both 1: stay IDLE (abort wins).
- CLEAR (exactly 1 cycle):
  - dir_r=0: t=q, so the bank goes to all-zeros at the next edge.
  - dir_r=1: t=~q, so the bank goes to all-ones at the next edge.
  - next=COUNT.
- COUNT:
  - If q==limit_r: t=0, next=DONE.
  - Else, up: t[0]=1, t[i]=&q[i-1:0].
  - Else, down: t[0]=1, t[i]=&(~q[i-1:0]).
  - Counting is modulo 2^WIDTH. Wrap-around is legal but unreachable, since the terminal is hit first.
- DONE (1 cycle): t=0, done=1, next=IDLE.
- Latency from the start-sampling edge to the done cycle, with N = limit (up) or (2^WIDTH-1)-limit (down):
  - CLEAR occupies 1 cycle.
  - COUNT occupies N+1 cycles.
  - done is high in cycle N+2 after the sampling edge.
- Abort:
  - abort=1 in CLEAR or COUNT: t=0 in that cycle, next=IDLE, no done pulse, q keeps its current value.
  - abort in IDLE or DONE is ignored, so DONE still completes its pulse.
- start while busy or in DONE is ignored. It is not queued.
- limit and dir changes after capture have no effect until the next start.
- up with limit=0, or down with limit=all-ones: COUNT matches immediately, t stays 0, done is 2 cycles after start.
- Asynchronous rst mid-sequence: state returns to IDLE and t drops to 0 immediately; no done. The bank is reset by the same rst.
- Exactly one of busy/done/idle holds at any time. busy and done are never high together.

Test Plan:
- WIDTH=4, reset, then start dir=0 limit=5: CLEAR 1 cycle, then q steps 0,1,2,3,4,5. t=0 on the cycle q==5, done pulses 1 cycle later, busy high for 7 cycles.
- Start dir=1 limit=12 from q=3: after CLEAR q=15, then 14,13,12. done 5 cycles after the start edge; t=4'b0000 in DONE.
- Start dir=0 limit=0: CLEAR zeroes q, done 2 cycles after start, q never leaves 0.
- Start dir=0 limit=9, assert abort when q=4: t=0, next cycle IDLE, q holds 4, done stays 0. A new start then re-clears to 0.
- start held high through an entire sequence, with limit changed to 2 mid-count: the first run ends at the original limit=6. The held start is accepted in the IDLE cycle after DONE, and the second run stops at 2.
- Assert rst asynchronously (between edges) during COUNT at q=7: busy and t go 0 immediately, done stays 0. start+abort together in IDLE: remains IDLE.
